// File: rtl/cache_mshr_fill_engine.sv
`default_nettype none
// ============================================================================
// Module  : cache_mshr_fill_engine
// Desc    : Drains the head MSHR entry: block read from memory, store-word
//           merge over the fill data, bank fill, then a one-cycle pop.
// Revision: 1.0 - initial release
// ============================================================================
module cache_mshr_fill_engine #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int UUID_W      = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          mshr_valid,
    input  logic [ADDR_W-1:0]             mshr_block_addr,
    input  logic [BLOCK_WORDS-1:0]        mshr_write_status,
    input  logic [BLOCK_WORDS*WORD_W-1:0] mshr_write_block,
    input  logic [UUID_W-1:0]             mshr_uuid,
    output logic                          mshr_pop,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_W-1:0]             mem_req_addr,
    input  logic                          mem_resp_valid,
    input  logic [WORD_W-1:0]             mem_resp_data,
    output logic                          fill_valid,
    input  logic                          fill_ready,
    output logic [ADDR_W-1:0]             fill_addr,
    output logic [BLOCK_WORDS*WORD_W-1:0] fill_data,
    output logic                          fill_dirty,
    output logic [UUID_W-1:0]             fill_uuid,
    output logic                          busy
);

    localparam int                 c_CNT_W     = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BLOCK_WORDS - 1);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_REQ  = 3'd1;
    localparam logic [2:0] c_S_RECV = 3'd2;
    localparam logic [2:0] c_S_FILL = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_state_next;
    logic [c_CNT_W-1:0]     r_beat;
    logic [ADDR_W-1:0]      r_addr;
    logic [BLOCK_WORDS-1:0] r_status;
    logic [UUID_W-1:0]      r_uuid;
    logic                   r_dirty;
    logic                   r_pop;
    logic                   r_req_valid;
    logic                   r_fill_valid;
    logic                   r_busy;

    logic w_capture;
    logic w_beat;

    assign w_capture = (r_state == c_S_IDLE) && mshr_valid;
    assign w_beat    = (r_state == c_S_RECV) && mem_resp_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                // A fully written block needs nothing from memory.
                if (mshr_valid) begin
                    w_state_next = (&mshr_write_status) ? c_S_FILL : c_S_REQ;
                end
            end
            c_S_REQ: begin
                if (mem_req_ready) begin
                    w_state_next = c_S_RECV;
                end
            end
            c_S_RECV: begin
                if (mem_resp_valid && (r_beat == c_LAST_BEAT)) begin
                    w_state_next = c_S_FILL;
                end
            end
            c_S_FILL: begin
                if (fill_ready) begin
                    w_state_next = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_state_next = c_S_IDLE;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they leave a flop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= c_S_IDLE;
            r_beat       <= '0;
            r_addr       <= '0;
            r_status     <= '0;
            r_uuid       <= '0;
            r_dirty      <= 1'b0;
            r_pop        <= 1'b0;
            r_req_valid  <= 1'b0;
            r_fill_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pop        <= (w_state_next == c_S_DONE);
            r_req_valid  <= (w_state_next == c_S_REQ);
            r_fill_valid <= (w_state_next == c_S_FILL);
            r_busy       <= (w_state_next != c_S_IDLE);
            if (w_capture) begin
                r_addr   <= mshr_block_addr;
                r_status <= mshr_write_status;
                r_uuid   <= mshr_uuid;
                r_dirty  <= |mshr_write_status;
            end
            if (w_beat) begin
                r_beat <= (r_beat == c_LAST_BEAT) ? '0 : r_beat + c_CNT_W'(1);
            end
        end
    end

    // Each word takes store data at capture; a memory beat lands only on unstored words.
    generate
        for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_word
            logic [WORD_W-1:0] r_word;
            logic              w_keep_beat;

            assign w_keep_beat = w_beat && (r_beat == c_CNT_W'(i)) && !r_status[i];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_word <= '0;
                end else if (w_capture) begin
                    r_word <= mshr_write_block[i*WORD_W +: WORD_W];
                end else if (w_keep_beat) begin
                    r_word <= mem_resp_data;
                end
            end

            assign fill_data[i*WORD_W +: WORD_W] = r_word;
        end
    endgenerate

    assign mshr_pop      = r_pop;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_addr;
    assign fill_valid    = r_fill_valid;
    assign fill_addr     = r_addr;
    assign fill_dirty    = r_dirty;
    assign fill_uuid     = r_uuid;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cache_mshr_fill_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_mshr_fill_engine
// Desc    : Randomized bench for cache_mshr_fill_engine with an entry-queue and
//           memory-responder reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_mshr_fill_engine;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int BW     = 4;
    localparam int UUID_W = 4;
    localparam int BLK_W  = BW * WORD_W;

    logic              CLK;
    logic              RST;
    logic              mshr_valid;
    logic [ADDR_W-1:0] mshr_block_addr;
    logic [BW-1:0]     mshr_write_status;
    logic [BLK_W-1:0]  mshr_write_block;
    logic [UUID_W-1:0] mshr_uuid;
    logic              mshr_pop;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [WORD_W-1:0] mem_resp_data;
    logic              fill_valid;
    logic              fill_ready;
    logic [ADDR_W-1:0] fill_addr;
    logic [BLK_W-1:0]  fill_data;
    logic              fill_dirty;
    logic [UUID_W-1:0] fill_uuid;
    logic              busy;

    cache_mshr_fill_engine #(
        .ADDR_W      (ADDR_W),
        .WORD_W      (WORD_W),
        .BLOCK_WORDS (BW),
        .UUID_W      (UUID_W)
    ) u_dut (
        .CLK               (CLK),
        .RST               (RST),
        .mshr_valid        (mshr_valid),
        .mshr_block_addr   (mshr_block_addr),
        .mshr_write_status (mshr_write_status),
        .mshr_write_block  (mshr_write_block),
        .mshr_uuid         (mshr_uuid),
        .mshr_pop          (mshr_pop),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .fill_valid        (fill_valid),
        .fill_ready        (fill_ready),
        .fill_addr         (fill_addr),
        .fill_data         (fill_data),
        .fill_dirty        (fill_dirty),
        .fill_uuid         (fill_uuid),
        .busy              (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [BW-1:0]     status;
        logic [BLK_W-1:0]  block;
        logic [UUID_W-1:0] uuid;
    } entry_t;

    entry_t            q[$];
    int                n_checks;
    int                n_errors;
    int                cycle;
    int                svc_start;
    int                beats_pending;
    int                beats_sent;
    bit                zero_wait;
    bit                rst_arm;
    bit                aborted;
    bit                force_stray;
    bit                in_service;
    bit                req_done;
    bit                pop_exp;
    bit                prev_pop;
    bit                req_seen_first;
    bit                fill_seen_first;
    logic [WORD_W-1:0] beats [BW];

    task automatic check_val(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic entry_t make_entry(input logic [ADDR_W-1:0] addr, input logic [BW-1:0] st,
                                          input logic [UUID_W-1:0] id);
        entry_t e;
        e.addr   = addr & ~ADDR_W'(BLK_W / 8 - 1);
        e.status = st;
        e.uuid   = id;
        for (int i = 0; i < BW; i++) e.block[i*WORD_W +: WORD_W] = $urandom;
        return e;
    endfunction

    function automatic entry_t rand_entry();
        logic [BW-1:0] st;
        int            sel;
        sel = $urandom_range(0, 3);
        st  = (sel == 0) ? '0 : (sel == 1) ? '1 : BW'($urandom);
        return make_entry($urandom, st, UUID_W'($urandom));
    endfunction

    // Stored words win; every other word is the memory beat of the same index.
    function automatic logic [BLK_W-1:0] merged(input entry_t e);
        logic [BLK_W-1:0] m;
        for (int i = 0; i < BW; i++)
            m[i*WORD_W +: WORD_W] = e.status[i] ? e.block[i*WORD_W +: WORD_W] : beats[i];
        return m;
    endfunction

    task automatic clear_service();
        in_service      = 1'b0;
        req_done        = 1'b0;
        pop_exp         = 1'b0;
        beats_pending   = 0;
        beats_sent      = 0;
        req_seen_first  = 1'b0;
        fill_seen_first = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pop"},        mshr_pop,      0);
        check_val({tag, "_req_valid"},  mem_req_valid, 0);
        check_val({tag, "_req_addr"},   mem_req_addr,  0);
        check_val({tag, "_fill_valid"}, fill_valid,    0);
        check_val({tag, "_fill_addr"},  fill_addr,     0);
        check_val({tag, "_fill_data"},  fill_data,     0);
        check_val({tag, "_fill_dirty"}, fill_dirty,    0);
        check_val({tag, "_fill_uuid"},  fill_uuid,     0);
        check_val({tag, "_busy"},       busy,          0);
    endtask

    task automatic step();
        entry_t e;
        bit     have;
        bit     full;
        @(negedge CLK);
        cycle++;
        if (rst_arm && beats_sent == 2) begin
            rst_arm        = 1'b0;
            RST            = 1'b1;
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            fill_ready     = 1'b0;
            mshr_valid     = 1'b0;
            #1;
            check_reset_outputs("rst_mid_recv");
            @(negedge CLK);
            cycle++;
            check_reset_outputs("rst_held");
            RST = 1'b0;
            clear_service();
            prev_pop    = 1'b0;
            force_stray = 1'b1;
        end
        have = (q.size() > 0);
        if (have) e = q[0];
        full = have && (&e.status);

        check_val("busy", busy, in_service);
        check_val("pop", mshr_pop, pop_exp);
        if (prev_pop) check_val("idle_after_pop", busy, 0);
        pop_exp = 1'b0;

        if (mem_req_valid) begin
            check_val("req_in_service", in_service, 1);
            check_val("req_addr", mem_req_addr, e.addr);
            check_val("req_full_write", full, 0);
            check_val("req_after_accept", req_done, 0);
            if (zero_wait && !req_seen_first) check_val("req_latency", cycle - svc_start, 1);
            req_seen_first = 1'b1;
        end

        if (fill_valid) begin
            check_val("fill_in_service", in_service, 1);
            check_val("fill_addr", fill_addr, e.addr);
            check_val("fill_data", fill_data, merged(e));
            check_val("fill_dirty", fill_dirty, |e.status);
            check_val("fill_uuid", fill_uuid, e.uuid);
            check_val("fill_beats", beats_sent, full ? 0 : BW);
            if (zero_wait && !fill_seen_first) check_val("fill_latency", cycle - svc_start, full ? 1 : 2 + BW);
            fill_seen_first = 1'b1;
        end

        if (mshr_pop) begin
            if (zero_wait) check_val("pop_latency", cycle - svc_start, full ? 2 : 3 + BW);
            if (have) q.delete(0);
            clear_service();
        end

        if (in_service && (cycle - svc_start) > 400) begin
            check_val("service_timeout", cycle - svc_start, 400);
            aborted = 1'b1;
        end

        // Memory responder: beats only after an accepted request, strays otherwise.
        if (beats_pending > 0 && (zero_wait || $urandom_range(0, 1) == 1)) begin
            mem_resp_data      = $urandom;
            beats[beats_sent]  = mem_resp_data;
            beats_sent++;
            beats_pending--;
            mem_resp_valid     = 1'b1;
        end else if (beats_pending == 0 && (force_stray || (!zero_wait && $urandom_range(0, 3) == 0))) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
            force_stray    = 1'b0;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
        end

        mem_req_ready = zero_wait ? 1'b1 : ($urandom_range(0, 2) == 0);
        if (mem_req_valid && mem_req_ready) begin
            beats_pending = BW;
            req_done      = 1'b1;
        end

        fill_ready = zero_wait ? 1'b1 : ($urandom_range(0, 2) == 0);
        if (fill_valid && fill_ready) pop_exp = 1'b1;

        // While an entry is latched the head inputs carry noise.
        have = (q.size() > 0);
        if (have) e = q[0];
        if (busy && !mshr_pop) begin
            mshr_valid        = 1'($urandom);
            mshr_block_addr   = $urandom;
            mshr_write_status = BW'($urandom);
            mshr_uuid         = UUID_W'($urandom);
            for (int i = 0; i < BW; i++) mshr_write_block[i*WORD_W +: WORD_W] = $urandom;
        end else if (have) begin
            mshr_valid        = 1'b1;
            mshr_block_addr   = e.addr;
            mshr_write_status = e.status;
            mshr_write_block  = e.block;
            mshr_uuid         = e.uuid;
            if (!busy) begin
                in_service = 1'b1;
                svc_start  = cycle;
            end
        end else begin
            mshr_valid = 1'b0;
        end
        prev_pop = mshr_pop;
    endtask

    task automatic run_queue();
        int guard;
        guard = 0;
        while ((q.size() > 0 || in_service || busy) && !aborted && guard < 20000) begin
            step();
            guard++;
        end
        if (guard >= 20000) begin
            check_val("run_guard", guard, 0);
            aborted = 1'b1;
        end
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        cycle             = 0;
        svc_start         = 0;
        zero_wait         = 1'b1;
        rst_arm           = 1'b0;
        aborted           = 1'b0;
        force_stray       = 1'b0;
        prev_pop          = 1'b0;
        clear_service();
        RST               = 1'b1;
        mshr_valid        = 1'b0;
        mshr_block_addr   = '0;
        mshr_write_status = '0;
        mshr_write_block  = '0;
        mshr_uuid         = '0;
        mem_req_ready     = 1'b0;
        mem_resp_valid    = 1'b0;
        mem_resp_data     = '0;
        fill_ready        = 1'b0;

        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;

        q.push_back(make_entry(32'h100, 4'b0000, 4'h1));
        run_queue();
        q.push_back(make_entry(32'h240, 4'b0101, 4'h9));
        run_queue();
        q.push_back(make_entry(32'h3c0, 4'b1111, 4'h3));
        run_queue();

        for (int i = 0; i < 3; i++) q.push_back(rand_entry());
        run_queue();

        zero_wait = 1'b0;
        for (int b = 0; b < 12 && !aborted; b++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) q.push_back(rand_entry());
            run_queue();
        end

        if (!aborted) begin
            q.push_back(make_entry(32'h500, 4'b0010, 4'h7));
            rst_arm = 1'b1;
            run_queue();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
